// File: rtl/riscv_core_dpath_xm_skid.sv
// Execute-to-memory result buffer: a two-entry skid buffer between the ALU and
// the M stage, with an optional operand-bypass lookup into the held entries.
// Optional feature macro: RISCV_XM_BYPASS_EN (bypass lookup compiled in when defined).
module riscv_core_dpath_xm_skid #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          squash,
  input  logic          x_val,
  output logic          x_rdy,
  input  logic [DW-1:0] x_result,
  input  logic [AW-1:0] x_waddr,
  input  logic          x_wen,
  output logic          m_val,
  input  logic          m_rdy,
  output logic [DW-1:0] m_result,
  output logic [AW-1:0] m_waddr,
  output logic          m_wen,
  input  logic [AW-1:0] byp_raddr,
  output logic          byp_hit,
  output logic [DW-1:0] byp_data
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [DW-1:0] result;
    logic [AW-1:0] waddr;
    logic          wen;
  } entry_t;

  state_t state, state_nxt;
  entry_t x_ent, skid;
  logic   push, pop;
  logic   ld_head_x, ld_head_skid, ld_skid;

  // x0 is never a real destination, so its write enable is dropped at capture
  assign x_ent = '{result: x_result, waddr: x_waddr, wen: x_wen & (x_waddr != '0)};
  assign push  = x_val & x_rdy;
  assign pop   = m_val & m_rdy;
  assign m_val = (state != EMPTY);

  // Next-state and register-load selection; squash overrides everything
  always_comb begin
    state_nxt    = state;
    ld_head_x    = 1'b0;
    ld_head_skid = 1'b0;
    ld_skid      = 1'b0;
    if (squash) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (push) begin
          state_nxt = ONE;
          ld_head_x = 1'b1;
        end
        ONE: begin
          if (push && pop) begin
            ld_head_x = 1'b1;
          end else if (push) begin
            state_nxt = TWO;
            ld_skid   = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        TWO: if (pop) begin
          state_nxt    = ONE;
          ld_head_skid = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // State and registered ready (ready is taken from the next state so it is a flop output)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      x_rdy <= 1'b1;
    end else begin
      state <= state_nxt;
      x_rdy <= (state_nxt != TWO);
    end
  end

  // Head (m_*) and skid entry registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_result <= '0;
      m_waddr  <= '0;
      m_wen    <= 1'b0;
      skid     <= '0;
    end else begin
      if (ld_head_x) begin
        m_result <= x_ent.result;
        m_waddr  <= x_ent.waddr;
        m_wen    <= x_ent.wen;
      end else if (ld_head_skid) begin
        m_result <= skid.result;
        m_waddr  <= skid.waddr;
        m_wen    <= skid.wen;
      end
      if (ld_skid) skid <= x_ent;
    end
  end

`ifdef RISCV_XM_BYPASS_EN
  // Bypass lookup; the skid entry is younger than head so it wins a double hit
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    if (byp_raddr != '0) begin
      if (state == TWO && skid.wen && skid.waddr == byp_raddr) begin
        byp_hit  = 1'b1;
        byp_data = skid.result;
      end else if (m_val && m_wen && m_waddr == byp_raddr) begin
        byp_hit  = 1'b1;
        byp_data = m_result;
      end
    end
  end
`else
  // Bypass compiled out: ports kept, outputs tied off
  logic byp_unused;
  assign byp_unused = ^byp_raddr;
  assign byp_hit    = 1'b0;
  assign byp_data   = '0;
`endif

endmodule

// File: tb/tb_riscv_core_dpath_xm_skid.sv
// Directed bench for the X->M skid buffer: a queue model of the buffer checks
// every output each cycle, and literal checks pin the documented scenarios.
module tb_riscv_core_dpath_xm_skid;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef RISCV_XM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 0, reset = 1, squash = 0;
  logic          x_val = 0, x_rdy, x_wen = 0;
  logic [DW-1:0] x_result = '0;
  logic [AW-1:0] x_waddr = '0;
  logic          m_val, m_rdy = 0, m_wen;
  logic [DW-1:0] m_result;
  logic [AW-1:0] m_waddr;
  logic [AW-1:0] byp_raddr = '0;
  logic          byp_hit;
  logic [DW-1:0] byp_data;

  int checks = 0, failures = 0;

  riscv_core_dpath_xm_skid #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .squash(squash),
    .x_val(x_val), .x_rdy(x_rdy), .x_result(x_result), .x_waddr(x_waddr), .x_wen(x_wen),
    .m_val(m_val), .m_rdy(m_rdy), .m_result(m_result), .m_waddr(m_waddr), .m_wen(m_wen),
    .byp_raddr(byp_raddr), .byp_hit(byp_hit), .byp_data(byp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] result;
    logic [AW-1:0] waddr;
    logic          wen;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a FIFO of at most two entries; pop happens first, then push
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else begin
      bit do_push, do_pop;
      ent_t e;
      do_push = x_val && (q.size() < 2);
      do_pop  = (q.size() > 0) && m_rdy;
      if (do_pop) void'(q.pop_front());
      if (squash) q.delete();
      else if (do_push) begin
        e.result = x_result;
        e.waddr  = x_waddr;
        e.wen    = x_wen && (x_waddr != 0);
        q.push_back(e);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      logic          e_hit;
      logic [DW-1:0] e_data;
      e_hit = 1'b0;
      e_data = '0;
      if (BYP && byp_raddr != 0) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (!e_hit && q[i].wen && q[i].waddr == byp_raddr) begin
            e_hit = 1'b1;
            e_data = q[i].result;
          end
        end
      end
      chk("model_m_val", m_val, q.size() > 0);
      chk("model_x_rdy", x_rdy, q.size() != 2);
      if (q.size() > 0) begin
        chk("model_m_result", m_result, q[0].result);
        chk("model_m_waddr", m_waddr, q[0].waddr);
        chk("model_m_wen", m_wen, q[0].wen);
      end
      chk("model_byp_hit", byp_hit, e_hit);
      chk("model_byp_data", byp_data, e_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] r, input logic [AW-1:0] a);
    x_val = v;
    x_result = r;
    x_waddr = a;
    x_wen = 1'b1;
  endtask

  initial begin
    step();
    step();
    reset = 0;
    #1;
    chk("rst_m_val", m_val, 0);
    chk("rst_x_rdy", x_rdy, 1);
    chk("rst_m_result", m_result, 0);
    chk("rst_m_waddr", m_waddr, 0);
    chk("rst_m_wen", m_wen, 0);
    chk("rst_byp_hit", byp_hit, 0);
    chk("rst_byp_data", byp_data, 0);

    // Streaming at full rate
    m_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h11 * (i + 1), AW'(i + 1));
      step();
      chk("stream_m_val", m_val, 1);
      chk("stream_m_result", m_result, 32'h11 * (i + 1));
      chk("stream_m_waddr", m_waddr, i + 1);
      chk("stream_x_rdy", x_rdy, 1);
    end
    x_val = 0;
    step();
    chk("stream_drain", m_val, 0);

    // Stall absorbs two entries
    m_rdy = 0;
    drive(1, 32'hA, 5);
    step();
    chk("stall_x_rdy1", x_rdy, 1);
    chk("stall_head1", m_result, 32'hA);
    drive(1, 32'hB, 6);
    step();
    chk("stall_x_rdy0", x_rdy, 0);
    chk("stall_head2", m_result, 32'hA);
    byp_raddr = 6;
    #1;
    chk("stall_byp_hit", byp_hit, BYP);
    chk("stall_byp_data", byp_data, BYP ? 32'hB : 32'h0);
    x_val = 0;
    m_rdy = 1;
    step();
    chk("release_b", m_result, 32'hB);
    chk("release_rdy", x_rdy, 1);
    step();
    chk("release_empty", m_val, 0);

    // x0 destination and bypass priority
    m_rdy = 0;
    drive(1, 32'hDEAD, 0);
    step();
    x_val = 0;
    byp_raddr = 0;
    #1;
    chk("x0_m_wen", m_wen, 0);
    chk("x0_byp_hit", byp_hit, 0);
    m_rdy = 1;
    step();
    m_rdy = 0;
    drive(1, 32'h1, 7);
    step();
    drive(1, 32'h2, 7);
    step();
    x_val = 0;
    byp_raddr = 7;
    #1;
    chk("prio_byp_hit", byp_hit, BYP);
    chk("prio_byp_data", byp_data, BYP ? 32'h2 : 32'h0);
    byp_raddr = 9;
    #1;
    chk("miss_byp_hit", byp_hit, 0);
    chk("miss_byp_data", byp_data, 0);

    // Squash in TWO with a completing pop
    chk("sq_head", m_result, 32'h1);
    squash = 1;
    m_rdy = 1;
    drive(1, 32'h77, 4);
    step();
    squash = 0;
    x_val = 0;
    chk("sq_m_val", m_val, 0);
    chk("sq_x_rdy", x_rdy, 1);

    // Squash in ONE drops a same-cycle push
    m_rdy = 0;
    drive(1, 32'h55, 3);
    step();
    squash = 1;
    drive(1, 32'h66, 4);
    step();
    squash = 0;
    x_val = 0;
    chk("sq_push_drop", m_val, 0);
    step();
    chk("sq_push_drop2", m_val, 0);

    // Mixed traffic with patterned stalls, checked by the model each cycle
    begin
      logic [DW-1:0] nxt = 32'h100;
      for (int i = 0; i < 40; i++) begin
        logic acc;
        m_rdy = (i % 3) != 0;
        if (!x_val) drive((i % 4) != 1, nxt, AW'(i % 8));
        byp_raddr = AW'((i + 1) % 8);
        acc = x_val & x_rdy;
        step();
        if (acc) begin
          nxt = nxt + 32'h11;
          x_val = 0;
        end
      end
      x_val = 0;
    end

    // Async reset with two entries held
    m_rdy = 0;
    drive(1, 32'hC, 9);
    step();
    drive(1, 32'hD, 9);
    step();
    x_val = 0;
    byp_raddr = 9;
    #2;
    reset = 1;
    #1;
    chk("arst_m_val", m_val, 0);
    chk("arst_x_rdy", x_rdy, 1);
    chk("arst_byp_hit", byp_hit, 0);
    chk("arst_m_result", m_result, 0);
    step();
    reset = 0;
    step();
    chk("post_rst_m_val", m_val, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
